// File: rtl/pingpong_rd_sched.sv
// Ping/pong bank read scheduler: drains full banks in strict alternation, one burst each.
// Optional stall watchdog enabled by defining PPRS_TIMEOUT_EN.
`timescale 1ns/1ps
module pingpong_rd_sched #(
    parameter int BURST_LEN   = 80,
    parameter int CNT_W       = 7,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       bank_full,
    input  logic             sink_ready,
    output logic [1:0]       rd_en,
    output logic [1:0]       bank_release,
    output logic             busy,
    output logic             cur_bank,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {IDLE, PING, PONG, RELEASE} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [7:0]       STALL_LAST = 8'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic             next_bank_q, next_bank_d;
    logic             cur_bank_q, cur_bank_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             in_burst, beat, last_beat, stall_abort;

    assign in_burst  = (state_q == PING) || (state_q == PONG);
    assign beat      = in_burst && sink_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

`ifdef PPRS_TIMEOUT_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    // Counter only runs across consecutive stalled burst cycles; any beat or leaving the burst clears it.
    always_comb begin
        stall_cnt_d   = 8'd0;
        stall_abort   = 1'b0;
        if (in_burst && !sink_ready) begin
            if (stall_cnt_q == STALL_LAST) begin
                stall_abort = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + 8'd1;
            end
        end
        timeout_err_d = timeout_err_q | stall_abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = ^STALL_LAST;
    assign stall_abort      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        next_bank_d = next_bank_q;
        cur_bank_d  = cur_bank_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                // Only the bank whose turn it is may start a burst.
                if (bank_full[next_bank_q]) begin
                    state_d    = next_bank_q ? PONG : PING;
                    cur_bank_d = next_bank_q;
                end
            end
            PING, PONG: begin
                if (beat) begin
                    if (last_beat) begin
                        state_d    = RELEASE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (stall_abort) begin
                    state_d    = RELEASE;
                    beat_cnt_d = '0;
                end
            end
            RELEASE: begin
                state_d     = IDLE;
                next_bank_d = ~next_bank_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            next_bank_q <= 1'b0;
            cur_bank_q  <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            next_bank_q <= next_bank_d;
            cur_bank_q  <= cur_bank_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign rd_en        = beat ? (cur_bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign bank_release = (state_q == RELEASE) ? (cur_bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy         = (state_q != IDLE);
    assign cur_bank     = cur_bank_q;
    assign beat_cnt     = beat_cnt_q;

endmodule

// File: doc/pingpong_rd_sched.md
PINGPONG_RD_SCHED -- requirements
Module: pingpong_rd_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 80, beats per bank burst (2..127).
REQ-002 SHALL have parameter CNT_W, default 7, width of beat counter; BURST_LEN-1 fits in CNT_W.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, stall limit in cycles (1..255); used only when PPRS_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bank_full  input  2  level; bit0 ping, bit1 pong; bank holds one complete burst.
REQ-007 SHALL have port sink_ready  input  1  downstream accepts one beat this cycle.
REQ-008 SHALL have port rd_en  output  2  read strobe to ping (bit0) / pong (bit1); at most one bit high.
REQ-009 SHALL have port bank_release  output  2  one-cycle pulse: bank drained, writer may refill.
REQ-010 SHALL have port busy  output  1  high when state is not IDLE.
REQ-011 SHALL have port cur_bank  output  1  bank being served (0 ping, 1 pong).
REQ-012 SHALL have port beat_cnt  output  CNT_W  beats read in current burst.
REQ-013 SHALL have port timeout_err  output  1  sticky stall-abort flag.

Function
REQ-014 SHALL implement states IDLE, PING, PONG, RELEASE; register next_bank selects strict ping/pong alternation.
REQ-015 IDLE: when bank_full[next_bank]=1 at cycle N, SHALL enter PING (next_bank=0) or PONG (next_bank=1) at N+1; bank_full[~next_bank] alone SHALL NOT start a burst.
REQ-016 PING/PONG: rd_en[cur_bank] SHALL equal sink_ready combinationally; other bit 0; first strobe possible at N+1.
REQ-017 beat_cnt SHALL increment on each rd_en beat, and clear to 0 on entry to RELEASE.
REQ-018 A beat with beat_cnt=BURST_LEN-1 SHALL be the last beat; state SHALL be RELEASE next cycle; no further rd_en in that burst.
REQ-019 RELEASE (one cycle): bank_release[cur_bank] SHALL be 1, next_bank SHALL toggle, state SHALL return to IDLE next cycle.
REQ-020 Minimum gap between last beat of one burst and first beat of next SHALL be 2 cycles (RELEASE, IDLE).
REQ-021 bank_full deasserting mid-burst SHALL be ignored; burst completes.
REQ-022 Both bank_full bits high in IDLE SHALL serve only next_bank.
REQ-023 cur_bank SHALL update on entry to PING/PONG and hold through RELEASE.
REQ-024 bank_release bits SHALL never both be high; rd_en SHALL be 0 in IDLE and RELEASE.

Reset
REQ-025 rst high SHALL asynchronously force state IDLE, next_bank 0, cur_bank 0, beat_cnt 0, busy 0, bank_release 0, timeout_err 0, stall counter 0; rd_en 0 while rst high.
REQ-026 Reset mid-burst SHALL abort without a bank_release pulse; first burst after reset SHALL be ping.

Configuration
REQ-027 With PPRS_TIMEOUT_EN defined: 8-bit stall counter SHALL count consecutive PING/PONG cycles with sink_ready=0, clear on any beat; on reaching TIMEOUT_CYC SHALL enter RELEASE next cycle (release pulse issued, partial burst abandoned) and set timeout_err until reset.
REQ-028 Without PPRS_TIMEOUT_EN: no stall counter; burst waits indefinitely; timeout_err tied 0.

Verification
REQ-029 Reset, bank_full=01, sink_ready=1 -> 80 consecutive rd_en=01 starting cycle 1, bank_release=01 pulse one cycle after beat 80, busy low after.
REQ-030 bank_full=11 constant, sink_ready=1 -> bursts alternate ping,pong,ping; 80 beats each; exactly 2 idle cycles between bursts.
REQ-031 bank_full=10 after reset -> no rd_en for 1000 cycles; then bank_full=11 -> ping burst first.
REQ-032 sink_ready toggling 1/0 every cycle -> exactly 80 beats over 159 cycles, beat_cnt monotonic 0..79, one release pulse.
REQ-033 rst pulsed at beat 40 of ping burst -> outputs reset immediately, no bank_release; next burst ping, beat_cnt restarts 0.
REQ-034 PPRS_TIMEOUT_EN defined, sink_ready held 0 after beat 10 -> release pulse after 255 stall cycles, timeout_err=1 until rst; undefined -> rd_en idle, busy=1, no release.
